// File: rtl/ucie_ctl_csr_pkg.sv
// ucie_ctl_csr_pkg: register map, per-bit attribute tables and protocol FSM state for the UCIe CSR bank
package ucie_ctl_csr_pkg;
  localparam int CSR_NUM_REGS = 16;
  localparam int CSR_DATA_W = 32;
  typedef logic [CSR_NUM_REGS-1:0][CSR_DATA_W-1:0] tab_t;
  typedef enum logic [3:0] {R_CTRL = 4'd0, R_STATUS = 4'd1, R_ADVCAP = 4'd4, R_WO = 4'd9} reg_idx_e;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  function automatic tab_t f_tab(input logic [CSR_DATA_W-1:0] dflt, ctrl, status, advcap, wo);
    tab_t t;
    for (int k = 0; k < CSR_NUM_REGS; k++) t[k] = dflt;
    t[R_CTRL] = ctrl;
    t[R_STATUS] = status;
    t[R_ADVCAP] = advcap;
    t[R_WO] = wo;
    return t;
  endfunction
  localparam tab_t RESET_VAL = f_tab('0, '0, '0, 32'h0000_0011, 32'h0000_00C3);
  localparam tab_t P_WMASK   = f_tab('1, ~32'hFFE0_03FC, '0, 32'hFF00_000F, '1);
  localparam tab_t A_WMASK   = f_tab('0, '0, '0, 32'hFF00_00F0, '1);
  localparam tab_t W1C_MASK  = f_tab('0, '0, 32'h0000_00FF, '0, '0);
  localparam tab_t WO_MASK   = f_tab('0, '0, '0, '0, '1);
endpackage

// File: rtl/ucie_ctl_rr_arb.sv
// ucie_ctl_rr_arb: round-robin arbiter, combinational one-hot grant, pointer moves past the winner
module ucie_ctl_rr_arb #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] r_ptr;
  int w_sel, w_dist;
  always_comb begin
    w_sel = N;
    w_dist = N;
    o_grant = '0;
    for (int i = 0; i < N; i++)
      if (i_req[i] && (i - int'(r_ptr) + N) % N < w_dist) begin
        w_dist = (i - int'(r_ptr) + N) % N;
        w_sel = i;
      end
    for (int i = 0; i < N; i++) o_grant[i] = (i == w_sel);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= '0;
    else if (w_sel < N) r_ptr <= PW'((w_sel + 1) % N);
endmodule

// File: rtl/ucie_ctl_csr_mc.sv
// ucie_ctl_csr_mc: UCIe controller CSR bank with APB-style protocol port and arbitrated adapter write channels
module ucie_ctl_csr_mc import ucie_ctl_csr_pkg::*; #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = CSR_DATA_W,
  parameter int NUM_REGS    = CSR_NUM_REGS,
  parameter int BASE_ADDR   = 'h10,
  parameter int N_ADP       = 2,
  parameter int ADVCAP_IDX  = 4,
  parameter int RETRAIN_BIT = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_P_Select,
  input  logic                    i_P_Enable,
  input  logic                    i_P_WR,
  input  logic [ADDR_W-1:0]       i_P_addr,
  input  logic [DATA_W-1:0]       i_P_WDATA,
  output logic                    o_P_Ready,
  output logic [DATA_W-1:0]       o_P_RDATA,
  output logic                    o_P_SlvErr,
  input  logic [N_ADP-1:0]        i_A_Valid,
  input  logic [N_ADP*ADDR_W-1:0] i_A_addr,
  input  logic [N_ADP*DATA_W-1:0] i_A_WDATA,
  output logic [N_ADP-1:0]        o_A_Ready,
  output logic                    o_A_Err,
  output logic [DATA_W-1:0]       o_Advcap,
  output logic                    o_retrain
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int HI = BASE_ADDR + 4 * NUM_REGS;
  function automatic logic f_hit(input logic [ADDR_W-1:0] a);
    return a[1:0] == 2'b00 && 32'(a) >= BASE_ADDR && 32'(a) < HI;
  endfunction
  function automatic logic [IW-1:0] f_idx(input logic [ADDR_W-1:0] a);
    return IW'((a - ADDR_W'(BASE_ADDR)) >> 2);
  endfunction
  state_t                           r_state;
  logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs, w_next;
  logic [NUM_REGS-1:0]              r_lock, w_lock_next;
  logic                             r_ready, r_slverr, r_retrain, r_aerr;
  logic [DATA_W-1:0]                r_rdata, w_a_wdata, w_am;
  logic [ADDR_W-1:0]                w_a_addr;
  logic [N_ADP-1:0]                 w_grant;
  logic                             w_a_acc, w_a_hit, w_p_go, w_p_hit, w_p_we;
  logic [IW-1:0]                    w_p_idx, w_a_idx;
  ucie_ctl_rr_arb #(.N(N_ADP)) u_arb (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_A_Valid), .o_grant(w_grant));
  assign w_a_acc = |w_grant;
  assign w_a_hit = f_hit(w_a_addr);
  assign w_a_idx = f_idx(w_a_addr);
  assign w_p_go  = r_state == SETUP && i_P_Select && i_P_Enable;
  assign w_p_hit = f_hit(i_P_addr);
  assign w_p_idx = f_idx(i_P_addr);
  assign w_p_we  = w_p_go && i_P_WR && w_p_hit;
  always_comb begin
    w_a_addr = '0;
    w_a_wdata = '0;
    for (int i = 0; i < N_ADP; i++)
      if (w_grant[i]) begin
        w_a_addr = i_A_addr[i*ADDR_W +: ADDR_W];
        w_a_wdata = i_A_WDATA[i*DATA_W +: DATA_W];
      end
  end
  // Adapter update is layered on top of the protocol update so it wins overlaps and set beats clear
  always_comb begin
    w_next = r_regs;
    w_lock_next = r_lock;
    w_am = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_p_we && w_p_idx == IW'(k))
        w_next[k] = ((r_regs[k] & ~P_WMASK[k]) | (i_P_WDATA & P_WMASK[k])) & ~(W1C_MASK[k] & i_P_WDATA);
      if (w_a_acc && w_a_hit && w_a_idx == IW'(k)) begin
        w_am = ~(WO_MASK[k] & {DATA_W{r_lock[k]}});
        w_next[k] = (w_next[k] & ~(A_WMASK[k] & w_am)) | (w_a_wdata & A_WMASK[k] & w_am) | (w_a_wdata & W1C_MASK[k] & w_am);
        w_lock_next[k] = r_lock[k] | (|WO_MASK[k]);
      end
    end
    w_next[0][RETRAIN_BIT] = 1'b0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_regs <= RESET_VAL;
      r_lock <= '0;
      r_aerr <= 1'b0;
      r_retrain <= 1'b0;
    end else begin
      r_regs <= w_next;
      r_lock <= w_lock_next;
      r_aerr <= w_a_acc && !w_a_hit;
      r_retrain <= w_p_we && w_p_idx == '0 && i_P_WDATA[RETRAIN_BIT];
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: r_state <= (i_P_Select && !i_P_Enable) ? SETUP : IDLE;
        SETUP:
          if (!i_P_Select) r_state <= IDLE;
          else if (i_P_Enable) begin
            r_state <= ACCESS;
            r_ready <= 1'b1;
            r_slverr <= !w_p_hit;
            r_rdata <= (w_p_hit && !i_P_WR) ? r_regs[w_p_idx] : '0;
          end
        ACCESS: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_slverr <= 1'b0;
          r_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign o_P_Ready  = r_ready;
  assign o_P_RDATA  = r_rdata;
  assign o_P_SlvErr = r_slverr;
  assign o_A_Ready  = w_grant;
  assign o_A_Err    = r_aerr;
  assign o_retrain  = r_retrain;
  assign o_Advcap   = r_regs[ADVCAP_IDX];
endmodule

// File: tb/tb_ucie_ctl_csr_mc.sv
// tb_ucie_ctl_csr_mc: directed vector table for the protocol port plus hand sequences for adapter corner cases
module tb_ucie_ctl_csr_mc;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_P_Select = 1'b0, i_P_Enable = 1'b0, i_P_WR = 1'b0;
  logic [7:0]  i_P_addr = '0;
  logic [31:0] i_P_WDATA = '0;
  logic        o_P_Ready, o_P_SlvErr, o_A_Err, o_retrain;
  logic [31:0] o_P_RDATA, o_Advcap;
  logic [1:0]  i_A_Valid = '0, o_A_Ready;
  logic [15:0] i_A_addr = '0;
  logic [63:0] i_A_WDATA = '0;
  int total = 0, bad = 0;
  logic [31:0] g_rd;
  logic        g_err, g_rdy, g_rdy2, g_rt, g_rt2;

  ucie_ctl_csr_mc dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_P_Select(i_P_Select), .i_P_Enable(i_P_Enable), .i_P_WR(i_P_WR),
    .i_P_addr(i_P_addr), .i_P_WDATA(i_P_WDATA),
    .o_P_Ready(o_P_Ready), .o_P_RDATA(o_P_RDATA), .o_P_SlvErr(o_P_SlvErr),
    .i_A_Valid(i_A_Valid), .i_A_addr(i_A_addr), .i_A_WDATA(i_A_WDATA),
    .o_A_Ready(o_A_Ready), .o_A_Err(o_A_Err), .o_Advcap(o_Advcap), .o_retrain(o_retrain)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        rt;
  } vec_t;
  vec_t vt[19];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic p_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_P_Select = 1'b1; i_P_Enable = 1'b0; i_P_WR = wr; i_P_addr = a; i_P_WDATA = d;
    @(negedge i_clk);
    i_P_Enable = 1'b1;
    @(negedge i_clk);
    g_rdy = o_P_Ready; g_rd = o_P_RDATA; g_err = o_P_SlvErr; g_rt = o_retrain;
    i_P_Select = 1'b0; i_P_Enable = 1'b0;
    @(negedge i_clk);
    g_rdy2 = o_P_Ready; g_rt2 = o_retrain;
  endtask

  task automatic p_rd(input logic [7:0] a, input logic [31:0] exp);
    p_xfer(1'b0, a, '0);
    chk("p_rd_ready", g_rdy, 1);
    chk("p_rd_err", g_err, 0);
    chk($sformatf("p_rd_data@%h", a), g_rd, exp);
  endtask

  task automatic p_wr(input logic [7:0] a, input logic [31:0] d);
    p_xfer(1'b1, a, d);
    chk("p_wr_ready", g_rdy, 1);
    chk("p_wr_err", g_err, 0);
  endtask

  task automatic a_wr(input int ch, input logic [7:0] a, input logic [31:0] d, input logic exp_err);
    @(negedge i_clk);
    i_A_Valid = 2'(1 << ch); i_A_addr = {a, a}; i_A_WDATA = {d, d};
    #1 chk("a_ready", {30'b0, o_A_Ready}, 32'(1 << ch));
    @(negedge i_clk);
    i_A_Valid = '0;
    chk($sformatf("a_err@%h", a), o_A_Err, exp_err);
    @(negedge i_clk);
    chk("a_err_drop", o_A_Err, 0);
  endtask

  task automatic both_wr(input logic [7:0] pa, input logic [31:0] pd, input int ch, input logic [7:0] aa, input logic [31:0] ad);
    @(negedge i_clk);
    i_P_Select = 1'b1; i_P_Enable = 1'b0; i_P_WR = 1'b1; i_P_addr = pa; i_P_WDATA = pd;
    @(negedge i_clk);
    i_P_Enable = 1'b1;
    i_A_Valid = 2'(1 << ch); i_A_addr = {aa, aa}; i_A_WDATA = {ad, ad};
    #1 chk("both_a_ready", {30'b0, o_A_Ready}, 32'(1 << ch));
    @(negedge i_clk);
    chk("both_p_ready", o_P_Ready, 1);
    chk("both_p_err", o_P_SlvErr, 0);
    i_P_Select = 1'b0; i_P_Enable = 1'b0; i_A_Valid = '0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1 chk("rst_advcap", o_Advcap, 32'h11);
    chk("rst_ready", o_P_Ready, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1'b0, 8'h20, 32'h0,         32'h0000_0011, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h10, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1};
    vt[2]  = '{1'b0, 8'h10, 32'h0,         32'h001F_F803, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 8'h10, 32'h0000_0400, 32'h0,         1'b0, 1'b1};
    vt[4]  = '{1'b0, 8'h10, 32'h0,         32'h0,         1'b0, 1'b0};
    vt[5]  = '{1'b1, 8'h10, 32'h0000_0003, 32'h0,         1'b0, 1'b0};
    vt[6]  = '{1'b0, 8'h10, 32'h0,         32'h0000_0003, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h18, 32'h1234_5678, 32'h0,         1'b0, 1'b0};
    vt[8]  = '{1'b0, 8'h18, 32'h0,         32'h1234_5678, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 8'h4C, 32'hCAFE_BABE, 32'h0,         1'b0, 1'b0};
    vt[10] = '{1'b0, 8'h4C, 32'h0,         32'hCAFE_BABE, 1'b0, 1'b0};
    vt[11] = '{1'b0, 8'h50, 32'h0,         32'h0,         1'b1, 1'b0};
    vt[12] = '{1'b0, 8'h0C, 32'h0,         32'h0,         1'b1, 1'b0};
    vt[13] = '{1'b1, 8'h4E, 32'h0,         32'h0,         1'b1, 1'b0};
    vt[14] = '{1'b0, 8'h4C, 32'h0,         32'hCAFE_BABE, 1'b0, 1'b0};
    vt[15] = '{1'b0, 8'hFF, 32'h0,         32'h0,         1'b1, 1'b0};
    vt[16] = '{1'b0, 8'h11, 32'h0,         32'h0,         1'b1, 1'b0};
    vt[17] = '{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0};
    vt[18] = '{1'b0, 8'h14, 32'h0,         32'h0,         1'b0, 1'b0};
    repeat (3) @(negedge i_clk);
    chk("rst_advcap_hold", o_Advcap, 32'h11);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_ready", o_P_Ready, 0);
    chk("post_rst_slverr", o_P_SlvErr, 0);
    chk("post_rst_rdata", o_P_RDATA, 0);
    chk("post_rst_a_ready", {30'b0, o_A_Ready}, 0);
    chk("post_rst_a_err", o_A_Err, 0);
    chk("post_rst_retrain", o_retrain, 0);
    chk("post_rst_advcap", o_Advcap, 32'h11);

    for (int i = 0; i < 19; i++) begin
      p_xfer(vt[i].wr, vt[i].addr, vt[i].wdata);
      chk($sformatf("v%0d_ready", i), g_rdy, 1);
      chk($sformatf("v%0d_ready_drop", i), g_rdy2, 0);
      chk($sformatf("v%0d_slverr", i), g_err, vt[i].err);
      if (!vt[i].wr || vt[i].err) chk($sformatf("v%0d_rdata", i), g_rd, vt[i].rdata);
      chk($sformatf("v%0d_retrain", i), g_rt, vt[i].rt);
      chk($sformatf("v%0d_retrain_drop", i), g_rt2, 0);
    end

    // SETUP abandoned before ENABLE: no access, no write
    @(negedge i_clk);
    i_P_Select = 1'b1; i_P_WR = 1'b1; i_P_addr = 8'h18; i_P_WDATA = 32'hDEAD_BEEF;
    @(negedge i_clk);
    i_P_Select = 1'b0;
    @(negedge i_clk);
    chk("abort_ready", o_P_Ready, 0);
    @(negedge i_clk);
    chk("abort_ready2", o_P_Ready, 0);
    p_rd(8'h18, 32'h1234_5678);

    // write-once lock on reg 9, protocol ignores lock, reset clears it
    a_wr(0, 8'h34, 32'hAD00_00AD, 1'b0);
    a_wr(0, 8'h34, 32'h0, 1'b0);
    a_wr(1, 8'h34, 32'h0000_0055, 1'b0);
    p_rd(8'h34, 32'hAD00_00AD);
    p_wr(8'h34, 32'h0000_1234);
    p_rd(8'h34, 32'h0000_1234);
    do_reset();
    p_rd(8'h34, 32'h0000_00C3);
    p_rd(8'h10, 32'h0);
    chk("advcap_after_reset", o_Advcap, 32'h11);

    // round-robin alternation, then pointer hold while idle
    @(negedge i_clk);
    i_A_Valid = 2'b11; i_A_addr = {8'h18, 8'h18}; i_A_WDATA = '0;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("rr_grant%0d", k), {30'b0, o_A_Ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge i_clk);
    end
    i_A_Valid = 2'b01;
    #1 chk("rr_single_ch0", {30'b0, o_A_Ready}, 32'd1);
    @(negedge i_clk);
    i_A_Valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("rr_idle%0d", k), {30'b0, o_A_Ready}, 32'd0);
      @(negedge i_clk);
    end
    i_A_Valid = 2'b11;
    #1 chk("rr_ptr_held", {30'b0, o_A_Ready}, 32'd2);
    @(negedge i_clk);
    i_A_Valid = 2'b00;
    chk("rr_no_err", o_A_Err, 0);
    p_rd(8'h18, 32'h0);

    // W1C status: adapter sets, protocol clears, same-cycle set beats clear
    a_wr(0, 8'h14, 32'h0000_000F, 1'b0);
    p_rd(8'h14, 32'h0000_000F);
    p_wr(8'h14, 32'h0000_0003);
    p_rd(8'h14, 32'h0000_000C);
    both_wr(8'h14, 32'h0000_00FF, 1, 8'h14, 32'h0000_0030);
    p_rd(8'h14, 32'h0000_0030);

    // same-cycle RW merge on ADVCAP
    both_wr(8'h20, 32'hFF00_00FF, 0, 8'h20, 32'hAD00_00AD);
    p_rd(8'h20, 32'hAD00_00AF);
    chk("advcap_merge", o_Advcap, 32'hAD00_00AF);

    // adapter decode misses are dropped
    a_wr(0, 8'h02, 32'hFFFF_FFFF, 1'b1);
    a_wr(1, 8'h36, 32'h0000_FFFF, 1'b1);
    a_wr(0, 8'h50, 32'h0000_0001, 1'b1);
    p_rd(8'h34, 32'h0000_00C3);
    p_rd(8'h40, 32'h0);
    p_rd(8'h10, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
